pts_sequencer: RTL
==================

# pts_sequencer

Parametrised, synchronous pulse-train sequencer. It holds a table of DEPTH output codes and steps through a programmed index window [start..last] on each external trigger, with a one-shot or loop mode. It sits between the host register interface and the pulse-output drivers as the next-generation replacement for the 32-channel controller. Every storage element is clocked by iClk, and the raw trigger is synchronised inside the block.

## Interface
- CODE_W, 32, output code width (channel count)
- IDX_W, 8, index width; DEPTH = 2**IDX_W entries
- IDLE_CODE, 0, value driven on oCode while IDLE
- iClk  in  1  system clock, all logic on rising edge
- iRst  in  1  asynchronous, active-low reset
- iSET_CODE_FLAG  in  1  one-cycle write strobe: storage[iSET_ADDR] <= iSET_CODE
- iSET_ADDR  in  IDX_W  table write address
- iSET_CODE  in  CODE_W  table write data
- iSET_INDEX_FLAG  in  1  one-cycle strobe: start <= iSET_INDEX
- iSET_INDEX  in  IDX_W  window start index
- iSET_LAST_FLAG  in  1  one-cycle strobe: last <= iSET_LAST
- iSET_LAST  in  IDX_W  window last index
- iMODE_LOOP  in  1  1 = wrap to start after last; 0 = stop at last
- iArm  in  1  one-cycle strobe: load index <= start, enter ARMED
- iAbort  in  1  one-cycle strobe: return to IDLE
- iTrigger  in  1  asynchronous trigger, rising edge advances index
- oCode  out  CODE_W  registered current code
- oIndex  out  IDX_W  current index
- oState  out  2  00 IDLE, 01 ARMED, 10 RUN, 11 DONE
- oDone  out  1  one-cycle pulse on entry to DONE
- oMissed  out  1  one-cycle pulse: trigger edge in IDLE/DONE, or write rejected

## Operation
- Reset values: state IDLE, index 0, start 0, last DEPTH-1, oCode IDLE_CODE, oDone 0, oMissed 0, trigger synchroniser 0. Table contents are not reset.
- Trigger path: 2-flop synchroniser, then a registered rising-edge detect produces trig_p, a one-clock pulse.
- IDLE: oCode = IDLE_CODE and index = start. Code, start and last writes are accepted. iArm goes to ARMED.
- ARMED: oCode = storage[index]. trig_p goes to RUN and advances the index.
- RUN: each trig_p advances the index.
- Advance rule: if index != last, index <= index+1, wrapping modulo DEPTH (DEPTH-1 -> 0). If index == last and iMODE_LOOP=1, index <= start and the state stays RUN. If index == last and iMODE_LOOP=0, the state goes to DONE and index holds at last.
- last < start is legal: the window wraps through DEPTH-1 -> 0. start == last gives a one-entry window.
- DONE: oCode holds storage[last]. trig_p pulses oMissed. iArm re-arms.
- Writes (iSET_CODE_FLAG, iSET_INDEX_FLAG, iSET_LAST_FLAG) are accepted only in IDLE or DONE. In ARMED or RUN they are dropped and pulse oMissed. A code write to the displayed index in DONE updates oCode one cycle later.
- Same-cycle priority: iAbort > iArm > trig_p. iArm in ARMED or RUN restarts at start. iAbort goes to IDLE (index <= start, oCode <= IDLE_CODE) and cancels any simultaneous write.
- Mid-operation reset returns all registers to reset values immediately, with no clock needed.

## Timing
- Table read is synchronous: oCode = storage[index] registered, 1 cycle after an index change.
- Trigger latency: if iTrigger rises before clock edge E0, trig_p is high in cycle E2, index updates at E3 and oCode at E4.
- iTrigger must stay high ≥2 clocks and low ≥2 clocks. Shorter pulses may be lost. Each qualified rising edge advances exactly one step.
- iArm at edge A: oState=ARMED and oIndex=start after A. oCode = storage[start] after A+1.
- oDone asserts in the same cycle oState becomes DONE.

## Test plan
- Reset, then load storage[k]=k*0x11 for k=0..7, start=2, last=5, loop=0, arm, 5 triggers -> oCode 0x22,0x33,0x44,0x55. oDone pulses on the 4th trigger. The 5th trigger pulses oMissed and oCode stays 0x55.
- Same table, loop=1, 6 triggers -> oIndex 2,3,4,5,2,3,4. oDone never asserts.
- Wrap window start=DEPTH-2, last=1 -> oIndex DEPTH-2, DEPTH-1, 0, 1, then DONE.
- Write during RUN -> table unchanged and oMissed=1 for one cycle. iAbort with iArm in the same cycle -> IDLE, oCode=IDLE_CODE.
- 1-clock iTrigger glitch and 2-clock pulse, check latency -> oCode changes exactly 4 edges after the sampled rising edge.
- Assert iRst low mid-RUN -> all outputs at reset values asynchronously. After release, arm restarts from start=0.

Source files
------------

// File: rtl/pts_sequencer.sv
// Pulse-train sequencer: steps through a programmed window of a code table,
// advancing one entry per synchronised trigger edge, in one-shot or loop mode.
module pts_sequencer #(
  parameter int                 CODE_W    = 32,
  parameter int                 IDX_W     = 8,
  parameter logic [CODE_W-1:0]  IDLE_CODE = '0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iSET_CODE_FLAG,
  input  logic [IDX_W-1:0]  iSET_ADDR,
  input  logic [CODE_W-1:0] iSET_CODE,
  input  logic              iSET_INDEX_FLAG,
  input  logic [IDX_W-1:0]  iSET_INDEX,
  input  logic              iSET_LAST_FLAG,
  input  logic [IDX_W-1:0]  iSET_LAST,
  input  logic              iMODE_LOOP,
  input  logic              iArm,
  input  logic              iAbort,
  input  logic              iTrigger,
  output logic [CODE_W-1:0] oCode,
  output logic [IDX_W-1:0]  oIndex,
  output logic [1:0]        oState,
  output logic              oDone,
  output logic              oMissed
);
  localparam int DEPTH = 2**IDX_W;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [CODE_W-1:0] mem [DEPTH];

  logic [1:0]        state, state_nx;
  logic [IDX_W-1:0]  index, index_nx;
  logic [IDX_W-1:0]  start_idx, last_idx;
  logic [CODE_W-1:0] code_q;
  logic              trig_s1, trig_s2, trig_s3, trig_p;
  logic              done_q, missed_q;

  logic idle_like, busy, wr_ok, any_wr, at_last, adv;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign busy      = !idle_like;
  assign wr_ok     = idle_like && !iAbort;
  assign any_wr    = iSET_CODE_FLAG || iSET_INDEX_FLAG || iSET_LAST_FLAG;
  assign at_last   = (index == last_idx);
  assign adv       = trig_p && busy && !iAbort && !iArm;

  // Two-flop synchroniser, then a registered edge detect on the synced level
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
      trig_p  <= 1'b0;
    end else begin
      trig_s1 <= iTrigger;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      trig_p  <= trig_s2 && !trig_s3;
    end
  end

  always_comb begin
    state_nx = state;
    index_nx = index;
    if (iAbort) begin
      state_nx = S_IDLE;
      index_nx = start_idx;
    end else if (iArm) begin
      state_nx = S_ARMED;
      index_nx = start_idx;
    end else if (adv) begin
      if (!at_last) begin
        state_nx = S_RUN;
        index_nx = index + 1'b1;
      end else if (iMODE_LOOP) begin
        state_nx = S_RUN;
        index_nx = start_idx;
      end else begin
        state_nx = S_DONE;
      end
    end else if (state == S_IDLE) begin
      // IDLE tracks start so a new start value shows on oIndex immediately
      index_nx = iSET_INDEX_FLAG ? iSET_INDEX : start_idx;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= S_IDLE;
      index     <= '0;
      start_idx <= '0;
      last_idx  <= '1;
      code_q    <= IDLE_CODE;
      done_q    <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      index    <= index_nx;
      done_q   <= adv && at_last && !iMODE_LOOP;
      missed_q <= !iAbort && ((any_wr && busy) || (trig_p && idle_like && !iArm));
      if (wr_ok && iSET_INDEX_FLAG) start_idx <= iSET_INDEX;
      if (wr_ok && iSET_LAST_FLAG)  last_idx  <= iSET_LAST;
      if (iAbort || state == S_IDLE) code_q <= IDLE_CODE;
      else                           code_q <= mem[index];
    end
  end

  // Table has no reset so it can map onto plain RAM
  always_ff @(posedge iClk) begin
    if (wr_ok && iSET_CODE_FLAG) mem[iSET_ADDR] <= iSET_CODE;
  end

  assign oCode   = code_q;
  assign oIndex  = index;
  assign oState  = state;
  assign oDone   = done_q;
  assign oMissed = missed_q;
endmodule
